// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of producer-side and FIFO-side signals around the write arbiter.
// No logic of its own; master is the arbiter, slave is producers plus FIFO.
// Backpressure is carried by req_ready (to producers) and fifo_full (from FIFO).
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_last;
   logic [NUM_REQ*DATA_WIDTH-1:0]  req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           fifo_push;
   logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din;
   logic                           fifo_full;
   logic [ID_WIDTH-1:0]            grant_id;
   logic                           busy;
   logic                           burst_ovf;

   modport master (
      input  req_valid, req_last, req_data, fifo_full,
      output req_ready, fifo_push, fifo_din, grant_id, busy, burst_ovf
   );

   modport slave (
      output req_valid, req_last, req_data, fifo_full,
      input  req_ready, fifo_push, fifo_din, grant_id, busy, burst_ovf
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet arbiter sharing one FIFO write port; beats tagged with source ID.
// Latency: 1 cycle from valid in IDLE to grant; beats then pass combinationally.
// Backpressure: fifo_full drops req_ready and push; grant is held until full clears.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16
) (
   input  logic              clk,
   input  logic              rstn,
   fifo_wr_arbiter_if.master bus
);
   localparam int NUM_ID = 2**ID_WIDTH;
   localparam int CNT_W  = $clog2(MAX_BURST) + 1;
   localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
   localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ-1);
   localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(MAX_BURST-1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t              state_q, state_d;
   logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_WIDTH-1:0] grant_q, grant_d;
   logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic                ovf_q, ovf_d;

   // Request vectors widened to the full ID space so a grant_id indexes them
   // directly; IDs at or above NUM_REQ read as never-valid.
   logic [NUM_ID-1:0]     valid_pad, last_pad, ready_pad;
   logic [DATA_WIDTH-1:0] data_arr [NUM_ID];

   logic                pick_vld;
   logic [ID_WIDTH-1:0] pick_idx;
   logic [ID_WIDTH:0]   sum;
   logic                locked, push;
   logic [ID_WIDTH-1:0] rr_next;

   assign valid_pad = NUM_ID'(bus.req_valid);
   assign last_pad  = NUM_ID'(bus.req_last);

   for (genvar g = 0; g < NUM_ID; g++) begin : g_data
      if (g < NUM_REQ) begin : g_used
         assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_unused
         assign data_arr[g] = '0;
      end
   end

   // Round-robin scan from rr_ptr; walking downward lets the nearest hit win.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      sum      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
         if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
         end
         if (valid_pad[sum[ID_WIDTH-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = sum[ID_WIDTH-1:0];
         end
      end
   end

   assign locked  = (state_q == LOCKED);
   assign push    = locked & valid_pad[grant_q] & ~bus.fifo_full;
   assign rr_next = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;

   // Only the granted producer sees ready, and only while the FIFO has room.
   always_comb begin
      ready_pad = '0;
      if (locked && !bus.fifo_full) begin
         ready_pad[grant_q] = 1'b1;
      end
   end

   assign bus.req_ready = ready_pad[NUM_REQ-1:0];
   assign bus.fifo_push = push;
   assign bus.fifo_din  = {grant_q, data_arr[grant_q]};
   assign bus.grant_id  = grant_q;
   assign bus.busy      = locked;
   assign bus.burst_ovf = ovf_q;

   // Next state: grant in IDLE, release on last beat or when the burst cap is hit.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      beat_cnt_d = beat_cnt_q;
      ovf_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d    = pick_idx;
               beat_cnt_d = '0;
               state_d    = LOCKED;
            end
         end
         LOCKED: begin
            if (push) begin
               if (last_pad[grant_q]) begin
                  state_d  = IDLE;
                  rr_ptr_d = rr_next;
               end else if (beat_cnt_q == CNT_MAX) begin
                  state_d  = IDLE;
                  rr_ptr_d = rr_next;
                  ovf_d    = 1'b1;
               end else begin
                  beat_cnt_d = beat_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         beat_cnt_q <= beat_cnt_d;
         ovf_q      <= ovf_d;
      end
   end
endmodule
